// File: rtl/vs_alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, controller states, flag bit positions.
package vs_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_ADDA = 4'd4,
    OP_MULA = 4'd5,
    OP_MAC  = 4'd6,
    OP_ROL  = 4'd7,
    OP_ROR  = 4'd8,
    OP_AND  = 4'd9,
    OP_OR   = 4'd10,
    OP_XOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_ETH  = 4'd13,
    OP_GTH  = 4'd14,
    OP_LTH  = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_DIVZ  = 2;
  localparam int unsigned FLAG_W     = 3;

endpackage

// File: rtl/vs_alu_div.sv
// Restoring shift-subtract divider: one quotient bit per clock, MSB first.
// The first bit is resolved on the start edge, so done pulses after W cycles in total.
module vs_alu_div
  import vs_alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic         div_zero
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  dsr;
  logic [CW-1:0] cnt;

  // One restoring step on {rem, quo}; a zero divisor naturally yields all-ones.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r,
                                               input logic [W-1:0] q,
                                               input logic [W-1:0] d);
    logic [W:0] trial;
    logic [W:0] diff;
    trial = {r, q[W-1]};
    diff  = trial - {1'b0, d};
    if (diff[W]) return {trial[W-1:0], q[W-2:0], 1'b0};
    else         return {diff[W-1:0],  q[W-2:0], 1'b1};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      quo      <= '0;
      dsr      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {rem, quo} <= div_step('0, dividend, divisor);
        dsr        <= divisor;
        div_zero   <= (divisor == '0);
        cnt        <= CW'(W - 1);
      end else if (cnt != '0) begin
        {rem, quo} <= div_step(rem, quo, dsr);
        cnt        <= cnt - CW'(1);
        done       <= (cnt == CW'(1));
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/vs_alu_seq.sv
// Sequential ALU with accumulator and valid/ready handshake on both sides.
// Single-cycle ops finish in EXEC; DIV runs W cycles in the iterative divider.
module vs_alu_seq
  import vs_alu_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter logic [W-1:0] ACC_RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   opcode,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] ALU_Out,
  output logic [W-1:0] acc,
  output logic [2:0]   flags
);

  state_e        state;
  state_e        state_nx;
  opcode_e       op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          accept;
  logic          div_start;
  logic          div_done;
  logic [W-1:0]  div_q;
  logic          div_zero;
  logic [W-1:0]  res_c;
  logic          carry_c;
  logic [W:0]    sum_c;
  logic [2*W-1:0] prod_c;
  logic [W-1:0]  wb_res;
  logic [FLAG_W-1:0] wb_flags;

  assign accept    = in_valid && in_ready;
  assign div_start = accept && (opcode_e'(opcode) == OP_DIV);

  vs_alu_div #(.W(W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (A),
    .divisor  (B),
    .done     (div_done),
    .quotient (div_q),
    .div_zero (div_zero)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (opcode_e'(opcode) == OP_DIV) ? DIV : EXEC;
      EXEC:    state_nx = HOLD;
      DIV:     if (div_done) state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Single-cycle datapath on the captured operands; everything truncates mod 2^W.
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    sum_c   = '0;
    prod_c  = '0;
    case (op_q)
      OP_ADD: begin
        sum_c   = {1'b0, a_q} + {1'b0, b_q};
        res_c   = sum_c[W-1:0];
        carry_c = sum_c[W];
      end
      OP_SUB: begin
        res_c   = a_q - b_q;
        carry_c = (a_q < b_q);
      end
      OP_MUL: begin
        prod_c  = (2*W)'(a_q) * (2*W)'(b_q);
        res_c   = prod_c[W-1:0];
        carry_c = |prod_c[2*W-1:W];
      end
      OP_ADDA: begin
        sum_c   = {1'b0, acc} + {1'b0, a_q};
        res_c   = sum_c[W-1:0];
        carry_c = sum_c[W];
      end
      OP_MULA: begin
        prod_c  = (2*W)'(acc) * (2*W)'(a_q);
        res_c   = prod_c[W-1:0];
        carry_c = |prod_c[2*W-1:W];
      end
      OP_MAC: begin
        prod_c  = (2*W)'(a_q) * (2*W)'(b_q);
        sum_c   = {1'b0, acc} + {1'b0, prod_c[W-1:0]};
        res_c   = sum_c[W-1:0];
        carry_c = (|prod_c[2*W-1:W]) | sum_c[W];
      end
      OP_ROL:  res_c = {a_q[W-2:0], a_q[W-1]};
      OP_ROR:  res_c = {a_q[0], a_q[W-1:1]};
      OP_AND:  res_c = a_q & b_q;
      OP_OR:   res_c = a_q | b_q;
      OP_XOR:  res_c = a_q ^ b_q;
      OP_NAND: res_c = ~(a_q & b_q);
      OP_ETH:  res_c = W'(a_q == b_q);
      OP_GTH:  res_c = W'(a_q > b_q);
      OP_LTH:  res_c = W'(a_q < b_q);
      default: res_c = '0;
    endcase
  end

  // Select what is written back on entry to HOLD.
  always_comb begin
    wb_flags = '0;
    if (state == DIV) begin
      wb_res              = div_q;
      wb_flags[FLAG_DIVZ] = div_zero;
    end else begin
      wb_res               = res_c;
      wb_flags[FLAG_CARRY] = carry_c;
    end
    wb_flags[FLAG_ZERO] = (wb_res == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= ACC_RST;
      ALU_Out   <= '0;
      flags     <= '0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == HOLD);
      if (accept) begin
        op_q <= opcode_e'(opcode);
        a_q  <= A;
        b_q  <= B;
      end
      if (state_nx == HOLD && state != HOLD) begin
        acc     <= wb_res;
        ALU_Out <= wb_res;
        flags   <= wb_flags;
      end
    end
  end

endmodule

// File: tb/tb_vs_alu_seq.sv
// Self-checking bench for vs_alu_seq: directed cases plus random ops against an arithmetic model.
module tb_vs_alu_seq;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_Out;
  logic [W-1:0] acc;
  logic [2:0]   flags;

  int passed = 0;
  int total  = 0;
  longint unsigned m_acc = 0;

  vs_alu_seq #(.W(W), .ACC_RST(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_Out   (ALU_Out),
    .acc       (acc),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference behaviour from plain unsigned arithmetic modulo 2^W.
  function automatic void model(input int op, input longint unsigned a, input longint unsigned b,
                                input longint unsigned ac, output longint unsigned r,
                                output bit c, output bit dz);
    longint unsigned m;
    longint unsigned p;
    longint unsigned s;
    m = 64'd1 << W;
    r = 0; c = 0; dz = 0;
    case (op)
      0:  begin s = a + b;  r = s % m; c = (s >= m); end
      1:  begin r = (a + m - b) % m; c = (a < b); end
      2:  begin p = a * b;  r = p % m; c = (p >= m); end
      3:  begin if (b == 0) begin r = m - 1; dz = 1; end else r = a / b; end
      4:  begin s = ac + a; r = s % m; c = (s >= m); end
      5:  begin p = ac * a; r = p % m; c = (p >= m); end
      6:  begin p = a * b; s = ac + (p % m); r = s % m; c = (p >= m) || (s >= m); end
      7:  r = (a * 2 + a / (m / 2)) % m;
      8:  r = a / 2 + (a % 2) * (m / 2);
      9:  r = a & b;
      10: r = a | b;
      11: r = a ^ b;
      12: r = (m - 1) - (a & b);
      13: r = (a == b) ? 1 : 0;
      14: r = (a > b) ? 1 : 0;
      15: r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
  endfunction

  // One full transaction: accept, latency, result/flags/acc, stall stability, consume.
  task automatic run_op(input string tag, input int op, input int a, input int b,
                        input int stall, input int lit);
    longint unsigned er;
    bit ec, edz;
    int n, lat;
    logic [2:0] ef;
    model(op, longint'(a), longint'(b), m_acc, er, ec, edz);
    ef = {edz, ec, (er == 0)};
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk({tag, ":ready"}, in_ready, 1);
    opcode = 4'(op); A = W'(a); B = W'(b); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; opcode = 4'($urandom); A = W'($urandom); B = W'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    chk({tag, ":latency"}, lat, (op == 3) ? W + 1 : 2);
    chk({tag, ":result"}, ALU_Out, er);
    chk({tag, ":acc"}, acc, er);
    chk({tag, ":flags"}, flags, ef);
    chk({tag, ":in_ready_busy"}, in_ready, 0);
    if (lit >= 0) chk({tag, ":literal"}, ALU_Out, lit);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, ":stall_valid"}, out_valid, 1);
      chk({tag, ":stall_ready"}, in_ready, 0);
      chk({tag, ":stall_out"}, {flags, acc, ALU_Out}, {ef, er[W-1:0], er[W-1:0]});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ":consumed"}, {out_valid, in_ready}, 2'b01);
    m_acc = er;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; A = '0; B = '0;
    #12;
    chk("reset_state", {out_valid, in_ready, flags, acc, ALU_Out}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_release_ready_low", in_ready, 0);
    @(negedge clk);
    chk("reset_release_ready", in_ready, 1);

    run_op("add",  0, 200, 100, 0, 44);
    chk("add_carry", flags, 3'b010);
    run_op("sub",  1, 5, 5, 1, 0);
    chk("sub_zero", flags, 3'b001);
    run_op("adda7", 4, 7, 0, 0, 7);
    run_op("adda3", 4, 3, 0, 0, 10);
    run_op("mac",  6, 3, 4, 5, 22);
    run_op("div",  3, 200, 7, 0, 28);
    run_op("div0", 3, 9, 0, 2, 255);
    chk("div0_flag", flags, 3'b100);
    run_op("rol",  7, 8'h81, 0, 0, 8'h03);
    run_op("ror",  8, 8'h01, 0, 0, 8'h80);
    run_op("gth",  14, 3, 9, 0, 0);
    run_op("lth",  15, 3, 9, 0, 1);
    run_op("mul_ovf", 2, 16, 16, 0, 0);
    run_op("eth",  13, 77, 77, 0, 1);

    for (int k = 0; k < 48; k++) begin
      int op, a, b;
      op = $urandom_range(0, 15);
      a  = $urandom_range(0, 255);
      b  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255);
      run_op($sformatf("rnd%0d_op%0d", k, op), op, a, b, $urandom_range(0, 2), -1);
    end

    // Reset in the middle of a divide must discard it.
    while (in_ready !== 1'b1) @(negedge clk);
    opcode = 4'd3; A = 8'd250; B = 8'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_state", {out_valid, in_ready, flags, acc, ALU_Out}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_ready", in_ready, 1);
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      chk("midreset_no_result", out_valid, 0);
    end
    m_acc = 0;
    run_op("post_reset_adda", 4, 5, 0, 0, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vs_alu_seq.md
VS_ALU_SEQ -- requirements
Module: vs_alu_seq

Interface
REQ-001 SHALL have parameter: W, 8, operand/accumulator/result width (4..32).
REQ-002 SHALL have parameter: ACC_RST, 0, accumulator reset value (W bits).
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: in_valid  input  1  request present.
REQ-006 SHALL have port: in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port: opcode  input  4  operation select.
REQ-008 SHALL have port: A  input  W  operand A.
REQ-009 SHALL have port: B  input  W  operand B.
REQ-010 SHALL have port: out_valid  output  1  result presented.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: ALU_Out  output  W  result.
REQ-013 SHALL have port: acc  output  W  current accumulator.
REQ-014 SHALL have port: flags  output  3  {div_zero, carry, zero} for the presented result.

Function
REQ-015 SHALL accept a request on a cycle where in_valid and in_ready are both 1; opcode, A and B SHALL be captured then and ignored otherwise.
REQ-016 SHALL use FSM states IDLE, EXEC, DIV, HOLD: IDLE->EXEC on accept for non-DIV ops; IDLE->DIV on accept for DIV; EXEC->HOLD after 1 cycle; DIV->HOLD after exactly W cycles; HOLD->IDLE when out_ready.
REQ-017 SHALL drive in_ready=1 only in IDLE; no request is accepted in the same cycle a result is consumed.
REQ-018 SHALL drive out_valid=1 only in HOLD; ALU_Out, flags and acc SHALL remain stable while out_valid=1 and out_ready=0.
REQ-019 SHALL give latency from accept to out_valid: 2 cycles for non-DIV ops, W+1 cycles for DIV.
REQ-020 SHALL implement opcodes: 0 ADD A+B; 1 SUB A-B; 2 MUL A*B; 3 DIV A/B; 4 ADDA acc+A; 5 MULA acc*A; 6 MAC acc+A*B; 7 ROL A rotate left 1; 8 ROR A rotate right 1; 9 AND; 10 OR; 11 XOR; 12 NAND; 13 ETH (A==B); 14 GTH (A>B); 15 LTH (A<B); comparisons yield 1 or 0 zero-extended to W.
REQ-021 SHALL treat all operands as unsigned and truncate every result to its low W bits (mod 2^W).
REQ-022 SHALL write every result to acc in the same cycle it enters HOLD; ALU_Out SHALL equal the new acc.
REQ-023 SHALL set carry = bit W of the W+1-bit sum for ADD/ADDA/MAC, = borrow (A<B) for SUB, = 1 if any truncated product bit is nonzero for MUL/MULA/MAC, else 0; MAC carry SHALL be the OR of product overflow and sum carry.
REQ-024 SHALL set zero = (result == 0) for every opcode.
REQ-025 SHALL, for DIV with B=0, produce all-ones result, set div_zero=1, still take W cycles; div_zero SHALL be 0 for all other cases.
REQ-026 SHALL compute DIV by restoring shift-subtract, one quotient bit per cycle, MSB first.

Reset
REQ-027 SHALL on rst_n=0 immediately force state IDLE, acc=ACC_RST, ALU_Out=0, flags=0, out_valid=0, in_ready=0 while asserted.
REQ-028 SHALL abandon any in-flight operation, including a partial divide, on reset, with no result emitted afterwards.
REQ-029 SHALL drive in_ready=1 on the first clock edge after rst_n deasserts.

Structure
REQ-030 SHALL place the opcode enumeration (16 named codes), state enumeration and flag bit indices in shared package vs_alu_pkg.
REQ-031 SHALL implement the iterative divider as sub-module vs_alu_div (start, W-parameterised, done pulse after W cycles, quotient, div_zero).

Verification
REQ-032 SHALL cover: W=8, reset released, ADD A=200 B=100 -> ALU_Out=44, carry=1, zero=0, out_valid 2 cycles after accept.
REQ-033 SHALL cover: SUB A=5 B=5 -> ALU_Out=0, zero=1, carry=0; then ADDA A=7 -> acc=7.
REQ-034 SHALL cover: DIV A=200 B=7 -> ALU_Out=28 exactly 9 cycles after accept; DIV A=9 B=0 -> ALU_Out=255, div_zero=1.
REQ-035 SHALL cover: MAC with acc=10, A=3, B=4 -> 22; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-036 SHALL cover: ROL A=8'h81 -> 8'h03; ROR A=8'h01 -> 8'h80; GTH A=3 B=9 -> 0, LTH -> 1.
REQ-037 SHALL cover: rst_n pulsed low mid-DIV -> out_valid stays 0, acc=ACC_RST, in_ready=1 one edge after release.
